// File: rtl/demux18.sv
// rtl/demux18.sv - one-to-eight registered demultiplexer with per-channel valid/ready handshakes
// Destination is the internal round-robin pointer in auto mode, otherwise sel.
module demux18 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic [2:0]     sel,
  input  logic           auto_mode,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [8*W-1:0] out_data,
  output logic [7:0]     out_valid,
  input  logic [7:0]     out_ready,
  output logic [2:0]     ptr,
  output logic [15:0]    acc_count
);

  logic [2:0]          dest;
  logic                accept;
  logic [7:0]          load;
  logic [7:0][W-1:0]   data_q, data_d;
  logic [7:0]          valid_q, valid_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [15:0]         cnt_q, cnt_d;

  // A full channel still accepts when its consumer drains it on the same edge.
  always_comb begin
    dest     = auto_mode ? ptr_q : sel;
    in_ready = rst_n & (~valid_q[dest] | out_ready[dest]);
    accept   = in_valid & in_ready;
    load     = accept ? (8'(1) << dest) : 8'h00;
    valid_d  = load | (valid_q & ~out_ready);
    data_d   = data_q;
    for (int k = 0; k < 8; k++) begin
      if (load[k]) data_d[k] = in_data;
    end
    ptr_d = ptr_q + 3'(accept & auto_mode);
    cnt_d = cnt_q + 16'(accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 8'h00;
      ptr_q   <= 3'd0;
      cnt_q   <= 16'd0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign ptr       = ptr_q;
  assign acc_count = cnt_q;

endmodule

// File: tb/tb_demux18.sv
// tb/tb_demux18.sv - randomized and directed checks of demux18 against a transaction-level model
module tb_demux18;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic [2:0]     sel;
  logic           auto_mode;
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] out_data;
  logic [7:0]     out_valid;
  logic [7:0]     out_ready;
  logic [2:0]     ptr;
  logic [15:0]    acc_count;

  demux18 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .auto_mode(auto_mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .ptr(ptr), .acc_count(acc_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each channel is a one-entry mailbox.
  bit       m_full [8];
  int       m_word [8];
  int       m_ptr;
  int       m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) begin m_full[k] = 0; m_word[k] = 0; end
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  function automatic int model_dest();
    return auto_mode ? m_ptr : int'(sel);
  endfunction

  function automatic bit model_ready();
    int d = model_dest();
    return rst_n && (!m_full[d] || out_ready[d]);
  endfunction

  function automatic logic [63:0] model_data();
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(m_word[k]);
    return v;
  endfunction

  function automatic logic [7:0] model_valid();
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  task automatic drive(input bit iv, input bit am, input int s, input int d, input logic [7:0] ordy);
    in_valid  = iv;
    auto_mode = am;
    sel       = 3'(s);
    in_data   = 8'(d);
    out_ready = ordy;
  endtask

  // One clock: check in_ready before the edge, advance the model, check state after.
  task automatic step(output bit accepted);
    int  d;
    bit  acc;
    #1;
    d   = model_dest();
    acc = in_valid && model_ready();
    check("in_ready", {63'd0, in_ready}, {63'd0, model_ready()});
    @(posedge clk);
    for (int k = 0; k < 8; k++) if (m_full[k] && out_ready[k]) m_full[k] = 0;
    if (acc) begin
      m_full[d] = 1;
      m_word[d] = int'(in_data);
      if (auto_mode) m_ptr = (m_ptr + 1) % 8;
      m_cnt = (m_cnt + 1) % 65536;
    end
    accepted = acc;
    #1;
    check("out_valid", {56'd0, out_valid}, {56'd0, model_valid()});
    check("out_data", out_data, model_data());
    check("ptr", {61'd0, ptr}, 64'(m_ptr));
    check("acc_count", {48'd0, acc_count}, 64'(m_cnt));
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 8'hA5, 8'h00);
    rst_n = 1'b0;
    model_reset();
    #2;
    check("rst_valid", {56'd0, out_valid}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("rst_no_accept", {48'd0, acc_count}, 64'd0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 8'h00);
  endtask

  bit acc;
  bit hold;
  logic [7:0] sweep [8] = '{8'd3, 8'd43, 8'd28, 8'd7, 8'd11, 8'd23, 8'd17, 8'd20};

  initial begin
    drive(0, 0, 0, 0, 8'h00);
    rst_n = 1'b0;
    model_reset();
    #3;
    check("por_valid", {56'd0, out_valid}, 64'd0);
    check("por_data", out_data, 64'd0);
    check("por_ptr", {61'd0, ptr}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Manual single word
    drive(1, 0, 1, 43, 8'h00); step(acc);
    drive(0, 0, 1, 0, 8'h00);
    check("man_valid", {56'd0, out_valid}, 64'h02);
    check("man_ch1", {56'd0, out_data[15:8]}, 64'd43);
    check("man_cnt", {48'd0, acc_count}, 64'd1);
    check("man_ptr", {61'd0, ptr}, 64'd0);
    drive(0, 0, 0, 0, 8'hFF); step(acc);

    // Backpressure on channel 2
    drive(1, 0, 2, 28, 8'h00); step(acc);
    drive(1, 0, 2, 99, 8'h00); #1;
    check("bp_stall", {63'd0, in_ready}, 64'd0);
    step(acc);
    check("bp_hold", {56'd0, out_data[23:16]}, 64'd28);
    drive(1, 0, 2, 99, 8'h04); #1;
    check("bp_release", {63'd0, in_ready}, 64'd1);
    step(acc);
    check("bp_ch2", {56'd0, out_data[23:16]}, 64'd99);
    check("bp_v2", {63'd0, out_valid[2]}, 64'd1);

    // Auto sweep then wrap with drain of channel 0
    do_reset();
    for (int i = 0; i < 8; i++) begin drive(1, 1, 0, sweep[i], 8'h00); step(acc); end
    check("sweep_valid", {56'd0, out_valid}, 64'hFF);
    check("sweep_ptr", {61'd0, ptr}, 64'd0);
    check("sweep_cnt", {48'd0, acc_count}, 64'd8);
    for (int k = 0; k < 8; k++) check("sweep_word", {56'd0, out_data[k*8 +: 8]}, {56'd0, sweep[k]});
    drive(1, 1, 0, 55, 8'h00); #1;
    check("sweep_full", {63'd0, in_ready}, 64'd0);
    step(acc);
    drive(1, 1, 0, 55, 8'h01); step(acc);
    check("wrap_ch0", {56'd0, out_data[7:0]}, 64'd55);
    check("wrap_v0", {63'd0, out_valid[0]}, 64'd1);
    check("wrap_ptr", {61'd0, ptr}, 64'd1);

    // Mode switch leaves the pointer alone
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 10 + i, 8'h00); step(acc); end
    drive(1, 0, 6, 17, 8'h00); step(acc);
    check("mode_ch6", {56'd0, out_data[55:48]}, 64'd17);
    check("mode_ptr", {61'd0, ptr}, 64'd3);
    drive(1, 1, 0, 77, 8'h00); step(acc);
    check("mode_ch3", {56'd0, out_data[31:24]}, 64'd77);
    check("mode_v3", {63'd0, out_valid[3]}, 64'd1);

    // Asynchronous reset between edges
    do_reset();
    for (int i = 0; i < 8; i++) begin drive(1, 1, 0, i + 1, 8'h00); step(acc); end
    drive(1, 0, 0, 9, 8'h01); step(acc);
    check("pre_valid", {56'd0, out_valid}, 64'hFF);
    check("pre_cnt", {48'd0, acc_count}, 64'd9);
    drive(0, 0, 0, 0, 8'h00);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", {56'd0, out_valid}, 64'd0);
    check("arst_ptr", {61'd0, ptr}, 64'd0);
    check("arst_cnt", {48'd0, acc_count}, 64'd0);
    check("arst_ready", {63'd0, in_ready}, 64'd0);
    check("arst_data", out_data, 64'd0);
    drive(1, 1, 0, 66, 8'h00);
    step(acc);
    rst_n = 1'b1;

    // Random traffic; a stalled offer is held stable until taken
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        auto_mode = ($urandom_range(0, 2) != 0);
        sel       = 3'($urandom_range(0, 7));
        in_data   = 8'($urandom);
      end
      out_ready = 8'($urandom) & 8'($urandom);
      step(acc);
      hold = in_valid && !acc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/demux18.md
DEMUX18 -- requirements
Module: demux18

Interface
REQ-001 Parameter: W, default 8, data width of the input byte and of each output channel.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_data  input  W  data word offered by upstream.
REQ-005 Port: sel  input  3  destination channel in manual mode (0..7).
REQ-006 Port: auto_mode  input  1  1 = destination is internal pointer ptr; 0 = destination is sel.
REQ-007 Port: in_valid  input  1  upstream offers in_data.
REQ-008 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port: out_data  output  8*W  channel k at bits [W*k+W-1 : W*k].
REQ-010 Port: out_valid  output  8  bit k = channel k buffer holds undelivered data.
REQ-011 Port: out_ready  input  8  bit k = consumer k takes data this cycle.
REQ-012 Port: ptr  output  3  current auto-mode destination pointer.
REQ-013 Port: acc_count  output  16  number of words accepted since reset.

Function
REQ-014 Destination dest SHALL be ptr when auto_mode=1, else sel, evaluated combinationally each cycle.
REQ-015 in_ready SHALL be combinational: rst_n high AND (out_valid[dest]=0 OR out_ready[dest]=1).
REQ-016 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; otherwise no state changes on the input side.
REQ-017 On accept, channel dest buffer SHALL load in_data and out_valid[dest] SHALL be 1 from the next cycle (latency 1 cycle).
REQ-018 Delivery SHALL occur on channel k when out_valid[k]=1 and out_ready[k]=1; out_valid[k] SHALL clear next cycle unless the same edge accepts new data for k.
REQ-019 Simultaneous delivery and accept on the same channel SHALL leave out_valid[k]=1 with the new word; no word lost or duplicated.
REQ-020 Each channel SHALL operate independently; delivery on channel j SHALL not affect channel k≠j.
REQ-021 out_data for channel k SHALL hold its last loaded value while out_valid[k]=0.
REQ-022 ptr SHALL increment by 1 on each accept in auto_mode, wrapping 7→0; accepts in manual mode and mode changes SHALL NOT alter ptr.
REQ-023 acc_count SHALL increment by 1 per accept in either mode, wrapping 16'hFFFF→0.
REQ-024 Upstream SHALL hold in_data, sel, auto_mode stable while in_valid=1 and in_ready=0; block behaviour otherwise undefined but SHALL not corrupt other channels.
REQ-025 out_ready[k] asserted while out_valid[k]=0 SHALL have no effect.

Reset
REQ-026 On rst_n low, immediately and independent of clk: out_valid=8'h00, out_data all zero, ptr=0, acc_count=0, in_ready=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words; first accept after release SHALL occur no earlier than the first rising edge with rst_n high.
REQ-028 No word presented while rst_n low SHALL be accepted.

Verification
REQ-029 Manual: auto_mode=0, sel=1, in_data=43, in_valid one cycle, out_ready=0 → next cycle out_valid=8'b0000_0010, channel 1 data=43, acc_count=1, ptr=0.
REQ-030 Backpressure: channel 2 holds 28, out_ready[2]=0, offer 99 to sel=2 → in_ready=0, channel 2 stays 28; raise out_ready[2] → in_ready=1 same cycle, next cycle channel 2=99, out_valid[2]=1.
REQ-031 Auto sweep: auto_mode=1, out_ready=8'h00, words 3,43,28,7,11,23,17,20 back-to-back → channel k holds k-th word, out_valid=8'hFF, ptr=0, acc_count=8; 9th word → in_ready=0.
REQ-032 Wrap with drain: continue REQ-031 with out_ready=8'h01, 9th word 55 → accepted, channel 0=55, out_valid[0]=1, ptr=1.
REQ-033 Mode switch: auto_mode=1 at ptr=3, switch to manual sel=6 word 17 → channel 6=17, ptr stays 3; back to auto → next word to channel 3.
REQ-034 Async reset: out_valid=8'hFF, acc_count=9, drop rst_n between clock edges → out_valid=0, ptr=0, acc_count=0, in_ready=0 before next edge.
